pipeline_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the uDLX core. It sequences the five-stage pipeline around the EX-stage forwarding mux. It detects load-use hazards that forwarding cannot cover and inserts one bubble for each. It flushes wrong-path instructions on a taken branch, and freezes the pipeline while the data memory holds off a MEM-stage access, with a bounded timeout.

---
 rtl/udlx_ctrl_pkg.sv | 15 +
 rtl/pipeline_hazard_ctrl_if.sv | 39 +++
 rtl/load_use_detect.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 79 +++++++
 tb/tb_pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/udlx_ctrl_pkg.sv
// udlx_ctrl_pkg: shared types and constants for the uDLX pipeline control blocks.
// Contents: FSM state encoding for the hazard controller, NOP instruction used
// by bubble paths, and the width of the MEM wait counter.
package udlx_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int WAIT_CNT_WIDTH = 8;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: bundle between the uDLX pipeline and its hazard controller.
// master: pipeline side, drives ID/EX/MEM status and receives stall/flush/bubble controls.
// slave : controller side, reads status and drives controls, timeout flag and stall count.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic [REG_ADDR_WIDTH-1:0] id_rs_addr_in;
    logic [REG_ADDR_WIDTH-1:0] id_rt_addr_in;
    logic                      id_rs_used_in;
    logic                      id_rt_used_in;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_in;
    logic                      ex_mem_rd_in;
    logic                      ex_branch_taken_in;
    logic                      mem_req_in;
    logic                      mem_ready_in;
    logic                      pc_stall_out;
    logic                      if_id_stall_out;
    logic                      if_id_flush_out;
    logic                      id_ex_bubble_out;
    logic                      ex_mem_stall_out;
    logic                      mem_wb_bubble_out;
    logic                      mem_timeout_out;
    logic [CNT_WIDTH-1:0]      stall_count_out;

    modport master (
        output id_rs_addr_in, id_rt_addr_in, id_rs_used_in, id_rt_used_in,
               ex_rd_addr_in, ex_mem_rd_in, ex_branch_taken_in, mem_req_in, mem_ready_in,
        input  pc_stall_out, if_id_stall_out, if_id_flush_out, id_ex_bubble_out,
               ex_mem_stall_out, mem_wb_bubble_out, mem_timeout_out, stall_count_out
    );

    modport slave (
        input  id_rs_addr_in, id_rt_addr_in, id_rs_used_in, id_rt_used_in,
               ex_rd_addr_in, ex_mem_rd_in, ex_branch_taken_in, mem_req_in, mem_ready_in,
        output pc_stall_out, if_id_stall_out, if_id_flush_out, id_ex_bubble_out,
               ex_mem_stall_out, mem_wb_bubble_out, mem_timeout_out, stall_count_out
    );
endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the ID instruction.
// Inputs : ID source addresses and use flags, EX destination and load flag.
// Output : lu_hit, a dependence that forwarding cannot cover this cycle.
module load_use_detect #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
    input  logic                      id_rs_used,
    input  logic                      id_rt_used,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic                      ex_mem_rd,
    output logic                      lu_hit
);
    // r0 is hard-wired zero, so a load targeting it never creates a dependence
    assign lu_hit = ex_mem_rd && (ex_rd_addr != '0) &&
                    ((id_rs_used && id_rs_addr == ex_rd_addr) ||
                     (id_rt_used && id_rt_addr == ex_rd_addr));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and MEM-wait freeze sequencing for uDLX.
// Ports: clk, rst_n (async, active low), bus (slave side of pipeline_hazard_ctrl_if)
//   carrying ID/EX/MEM status in and stall/flush/bubble controls, the sticky
//   mem_timeout_out flag and the saturating stall_count_out statistic out.
// Priority of events: MEM wait > branch flush > load-use.
module pipeline_hazard_ctrl
    import udlx_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 15,
    parameter int CNT_WIDTH      = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    pipeline_hazard_ctrl_if.slave bus
);
    hazard_state_t             state, next_state;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
    logic                      lu_hit, mem_hold, at_limit, wait_done;
    logic                      hold, flush, lu_stall;

    load_use_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_lu (
        .id_rs_addr (bus.id_rs_addr_in),
        .id_rt_addr (bus.id_rt_addr_in),
        .id_rs_used (bus.id_rs_used_in),
        .id_rt_used (bus.id_rt_used_in),
        .ex_rd_addr (bus.ex_rd_addr_in),
        .ex_mem_rd  (bus.ex_mem_rd_in),
        .lu_hit     (lu_hit)
    );

    assign mem_hold  = bus.mem_req_in && !bus.mem_ready_in;
    assign at_limit  = wait_cnt == WAIT_CNT_WIDTH'(MEM_TIMEOUT);
    // the wait ends on completion or abort; both release the pipeline this cycle
    assign wait_done = bus.mem_ready_in || at_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= next_state;
    end

    always_comb begin
        next_state = (state == MEM_WAIT) ? (wait_done ? RUN : MEM_WAIT) :
                     mem_hold            ? MEM_WAIT :
                     (state == RUN && !bus.ex_branch_taken_in && lu_hit) ? LU_STALL : RUN;
    end

    // gating with rst_n keeps every control low while reset is asserted
    always_comb begin
        hold     = rst_n && ((state == MEM_WAIT) ? !wait_done : mem_hold);
        flush    = rst_n && state != MEM_WAIT && !mem_hold && bus.ex_branch_taken_in;
        lu_stall = rst_n && state == RUN && !mem_hold && !bus.ex_branch_taken_in && lu_hit;
    end

    assign bus.pc_stall_out      = hold || lu_stall;
    assign bus.if_id_stall_out   = hold || lu_stall;
    assign bus.if_id_flush_out   = flush;
    assign bus.id_ex_bubble_out  = flush || lu_stall;
    assign bus.ex_mem_stall_out  = hold;
    assign bus.mem_wb_bubble_out = hold;

    // counts wait cycles including the one that raised the wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      wait_cnt <= '0;
        else if (next_state != MEM_WAIT) wait_cnt <= '0;
        else if (state == MEM_WAIT)      wait_cnt <= wait_cnt + WAIT_CNT_WIDTH'(1);
        else                             wait_cnt <= WAIT_CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                              bus.mem_timeout_out <= 1'b0;
        else if (state == MEM_WAIT && !bus.mem_ready_in && at_limit) bus.mem_timeout_out <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         bus.stall_count_out <= '0;
        else if (bus.pc_stall_out && !(&bus.stall_count_out)) bus.stall_count_out <= bus.stall_count_out + CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed plus random stimulus against a behavioural model
// of the hazard controller (MEM_TIMEOUT=4, CNT_WIDTH=4 so timeout and saturation are reachable).
module tb_pipeline_hazard_ctrl;
    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    bit m_wait;
    int m_waited;
    bit m_lu_prev;
    bit m_to;
    int m_cnt;

    pipeline_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(CW)) bus ();

    pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(5), .MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock cycle: apply inputs, compare against the model, advance the model past the edge
    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic rsu, input logic rtu, input logic ld, input logic br,
                        input logic req, input logic rdy);
        bit lu, pc, ifs, fl, bub, exs, wbb, nxt_lu, nxt_to;
        @(negedge clk);
        rst_n = r;
        bus.id_rs_addr_in = rs;
        bus.id_rt_addr_in = rt;
        bus.ex_rd_addr_in = rd;
        bus.id_rs_used_in = rsu;
        bus.id_rt_used_in = rtu;
        bus.ex_mem_rd_in = ld;
        bus.ex_branch_taken_in = br;
        bus.mem_req_in = req;
        bus.mem_ready_in = rdy;
        #1;
        if (!r) begin
            m_wait = 0; m_waited = 0; m_lu_prev = 0; m_to = 0; m_cnt = 0;
        end
        lu = ld && rd != 0 && ((rsu && rs == rd) || (rtu && rt == rd));
        {pc, ifs, fl, bub, exs, wbb, nxt_lu} = '0;
        nxt_to = m_to;
        if (!r) begin
        end else if (m_wait) begin
            if (rdy || m_waited == TO) begin
                m_wait = 0;
                if (!rdy) nxt_to = 1;
            end else begin
                {pc, ifs, exs, wbb} = 4'hF;
                m_waited++;
            end
        end else if (req && !rdy) begin
            {pc, ifs, exs, wbb} = 4'hF;
            m_wait = 1;
            m_waited = 1;
        end else if (br) begin
            fl = 1; bub = 1;
        end else if (lu && !m_lu_prev) begin
            pc = 1; ifs = 1; bub = 1; nxt_lu = 1;
        end
        check("controls", 32'({bus.pc_stall_out, bus.if_id_stall_out, bus.if_id_flush_out,
                                bus.id_ex_bubble_out, bus.ex_mem_stall_out, bus.mem_wb_bubble_out}),
              32'({pc, ifs, fl, bub, exs, wbb}));
        check("timeout", 32'(bus.mem_timeout_out), 32'(m_to));
        check("count", 32'(bus.stall_count_out), 32'(m_cnt));
        m_to = nxt_to;
        m_lu_prev = nxt_lu;
        if (pc && m_cnt < CMAX) m_cnt++;
    endtask

    task automatic idle(input logic r);
        step(r, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        idle(1'b0);
        idle(1'b0);
        check("reset_pc", 32'(bus.pc_stall_out), 32'd0);
        check("reset_count", 32'(bus.stall_count_out), 32'd0);
        idle(1'b1);

        // load r3 in EX, ID reads r3: one stall, then the same ID instruction proceeds
        step(1, 5'd3, 5'd0, 5'd3, 1, 0, 1, 0, 0, 0);
        check("lu_pc", 32'(bus.pc_stall_out), 32'd1);
        check("lu_bubble", 32'(bus.id_ex_bubble_out), 32'd1);
        step(1, 5'd3, 5'd0, 5'd3, 1, 0, 1, 0, 0, 0);
        check("lu_second", 32'(bus.pc_stall_out), 32'd0);
        check("lu_count", 32'(bus.stall_count_out), 32'd1);

        // load to r0 never stalls
        step(1, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0);
        check("r0_pc", 32'(bus.pc_stall_out), 32'd0);

        // branch beats load-use
        step(1, 5'd3, 5'd0, 5'd3, 1, 0, 1, 1, 0, 0);
        check("br_flush", 32'(bus.if_id_flush_out), 32'd1);
        check("br_pc", 32'(bus.pc_stall_out), 32'd0);

        // memory ready after 3 low cycles
        idle(1'b0);
        repeat (3) step(1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 0);
        step(1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 1);
        check("ready_wb", 32'(bus.mem_wb_bubble_out), 32'd0);
        idle(1'b1);
        check("mem_count", 32'(bus.stall_count_out), 32'd3);

        // memory never ready: abort after the timeout, flag is sticky until reset
        idle(1'b0);
        repeat (4) step(1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 0);
        step(1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 0);
        check("abort_pc", 32'(bus.pc_stall_out), 32'd0);
        idle(1'b1);
        check("timeout_set", 32'(bus.mem_timeout_out), 32'd1);
        repeat (3) idle(1'b1);
        check("timeout_sticky", 32'(bus.mem_timeout_out), 32'd1);
        repeat (2) step(1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 0);
        step(0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 0);
        check("reset_mid_timeout", 32'(bus.mem_timeout_out), 32'd0);
        check("reset_mid_pc", 32'(bus.pc_stall_out), 32'd0);
        idle(1'b1);

        // 17 load-use stalls saturate the 4-bit counter
        repeat (34) step(1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 0, 0, 0);
        idle(1'b1);
        check("saturate", 32'(bus.stall_count_out), 32'd15);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) < 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
